key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_pkg.sv | 25 ++
 rtl/key_debounce_ch.sv | 164 ++++++++++++++++
 rtl/key_debounce_array.sv | 34 +++
 tb/tb_key_debounce_array.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debounce array.
// Optional long-press detection is compiled in with `define KEY_LONG_PRESS_EN.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_DOWN         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } ch_state_e;

  // Raw keys are active-low, so "released" is the safe synchronizer reset value.
  localparam logic SYNC_RST_VAL = 1'b1;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_PRESS_EN = 1'b1;
`else
  localparam bit LONG_PRESS_EN = 1'b0;
`endif

  function automatic int cnt_width(input int cnt_max, input int long_max);
    return LONG_PRESS_EN ? $clog2(long_max + 1) : $clog2(cnt_max + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, debounce FSM, registered event pulses.
// Long-press pulse generation present only with `define KEY_LONG_PRESS_EN.
//
// state           | meaning
// ST_IDLE         | key released and accepted as released
// ST_PRESS_WAIT   | key seen pressed, counting stable pressed cycles
// ST_DOWN         | key accepted as pressed (long-press timing when enabled)
// ST_RELEASE_WAIT | key seen released, counting stable released cycles
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int CNT_MAX  = 1000000,
  parameter int LONG_MAX = 50000000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int            CW       = cnt_width(CNT_MAX, LONG_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MAX - 1);
  localparam logic [CW-1:0] LONG_SAT  = CW'(LONG_MAX);
  logic long_q, long_d;
  logic long_done_q, long_done_d;
`endif

  logic [1:0]    sync_q, sync_d;
  logic          key_sync_n;
  ch_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  always_comb begin
    sync_d = {sync_q[0], key_in_n};
  end

  assign key_sync_n = sync_q[1];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:         if (!key_sync_n) state_d = ST_PRESS_WAIT;
      ST_PRESS_WAIT:   if (key_sync_n) state_d = ST_IDLE;
                       else if (cnt_q == CNT_LAST) state_d = ST_DOWN;
      ST_DOWN:         if (key_sync_n) state_d = ST_RELEASE_WAIT;
      ST_RELEASE_WAIT: if (!key_sync_n) state_d = ST_DOWN;
                       else if (cnt_q == CNT_LAST) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    long_d      = 1'b0;
    long_done_d = long_done_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
`ifdef KEY_LONG_PRESS_EN
        long_done_d = 1'b0;
`endif
      end
      ST_PRESS_WAIT: begin
        if (key_sync_n) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      // In DOWN the counter measures continuous hold time since acceptance.
      ST_DOWN: begin
        if (key_sync_n) begin
          cnt_d = '0;
        end
`ifdef KEY_LONG_PRESS_EN
        else if (cnt_q == LONG_LAST) begin
          cnt_d       = LONG_SAT;
          long_d      = !long_done_q;
          long_done_d = 1'b1;
        end else if (cnt_q != LONG_SAT) begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      ST_RELEASE_WAIT: begin
        if (!key_sync_n) begin
          // The bounce-back edge already sees the key held, so it counts as one.
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q    <= {2{SYNC_RST_VAL}};
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_q      <= 1'b0;
      long_done_q <= 1'b0;
    end else begin
      long_q      <= long_d;
      long_done_q <= long_done_d;
    end
  end
  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent debounced key channels with press/release/long-press pulses.
// Long-press support is enabled by `define KEY_LONG_PRESS_EN; otherwise key_long is 0.
module key_debounce_array
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS   = 4,
  parameter int CNT_MAX  = 1000000,
  parameter int LONG_MAX = 50000000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .key_in_n    (key_in[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: directed timing cases plus random bouncing keys
// checked against a run-length reference model.
module tb_key_debounce_array;

  localparam int NK = 4;
  localparam int CM = 10;
  localparam int LM = 50;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_level, key_press, key_release, key_long;

  always #5 sys_clk = ~sys_clk;

  key_debounce_array #(.N_KEYS(NK), .CNT_MAX(CM), .LONG_MAX(LM)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level change is accepted once the synchronized pin has
  // disagreed with the debounced level on CNT_MAX+1 consecutive clock edges.
  bit            m_s0[NK], m_s1[NK], m_lvl[NK];
  int            m_run[NK];
`ifdef KEY_LONG_PRESS_EN
  int            m_lrun[NK];
  bit            m_done[NK];
`endif
  logic [NK-1:0] e_lvl, e_press, e_rel, e_long;

  task automatic model_reset();
    for (int i = 0; i < NK; i++) begin
      m_s0[i] = 1'b1; m_s1[i] = 1'b1; m_lvl[i] = 1'b0; m_run[i] = 0;
`ifdef KEY_LONG_PRESS_EN
      m_lrun[i] = 0; m_done[i] = 1'b0;
`endif
    end
    e_lvl = '0; e_press = '0; e_rel = '0; e_long = '0;
  endtask

  task automatic model_step();
    bit s, was;
    e_press = '0; e_rel = '0; e_long = '0;
    for (int i = 0; i < NK; i++) begin
      s = m_s1[i];
      m_s1[i] = m_s0[i];
      m_s0[i] = key_in[i];
      was = m_lvl[i];
`ifdef KEY_LONG_PRESS_EN
      if (was) begin
        if (!s) m_lrun[i]++; else m_lrun[i] = 0;
        if (m_lrun[i] == LM && !m_done[i]) begin
          e_long[i] = 1'b1;
          m_done[i] = 1'b1;
        end
      end
`endif
      if ((!s) != was) m_run[i]++; else m_run[i] = 0;
      if (m_run[i] == CM + 1) begin
        m_run[i] = 0;
        m_lvl[i] = !was;
        if (!was) begin
          e_press[i] = 1'b1;
`ifdef KEY_LONG_PRESS_EN
          m_lrun[i] = 0; m_done[i] = 1'b0;
`endif
        end else begin
          e_rel[i] = 1'b1;
        end
      end
      e_lvl[i] = m_lvl[i];
    end
  endtask

  task automatic compare();
    chk("key_level",   32'(key_level),   32'(e_lvl));
    chk("key_press",   32'(key_press),   32'(e_press));
    chk("key_release", 32'(key_release), 32'(e_rel));
    chk("key_long",    32'(key_long),    32'(e_long));
  endtask

  task automatic tick();
    @(posedge sys_clk);
    if (sys_rst_n) model_step();
    @(negedge sys_clk);
    compare();
  endtask

  task automatic apply_reset();
    key_in    = '1;
    sys_rst_n = 1'b0;
    model_reset();
    #1 compare();
    repeat (2) tick();
    sys_rst_n = 1'b1;
  endtask

  int hold[NK];
  int p0, p2, p3, l2, r2, r0x, r3x, np0, nr0, n1, lvl1, lvl0_low;

  initial begin
    key_in    = '1;
    sys_rst_n = 1'b0;
    model_reset();
    #1 compare();
    chk("rst_level", 32'(key_level), 32'd0);
    repeat (2) tick();
    sys_rst_n = 1'b1;

    // Held key, chattering key, long-held key, release bounce on key 0.
    p0 = -1; p2 = -1; l2 = -1; r2 = -1; np0 = 0; nr0 = 0; n1 = 0; lvl1 = 0; lvl0_low = 0;
    for (int k = 0; k < 120; k++) begin
      key_in[0] = (k >= 30 && k < 34);
      key_in[1] = (k < 100) ? (((k / 5) % 2) != 0) : 1'b1;
      key_in[2] = (k >= 80);
      key_in[3] = 1'b1;
      tick();
      if (key_press[0]) begin np0++; if (p0 < 0) p0 = k; end
      if (key_release[0]) nr0++;
      if (k >= 12 && !key_level[0]) lvl0_low++;
      if (key_press[1] || key_release[1] || key_long[1]) n1++;
      if (key_level[1]) lvl1++;
      if (key_press[2] && p2 < 0) p2 = k;
      if (key_long[2] && l2 < 0) l2 = k;
      if (key_release[2] && r2 < 0) r2 = k;
    end
    chk("press0_cyc", p0, 12);
    chk("press0_cnt", np0, 1);
    chk("rel0_bounce_cnt", nr0, 0);
    chk("lvl0_low_after12", lvl0_low, 0);
    chk("key1_pulses", n1, 0);
    chk("key1_level_hi", lvl1, 0);
    chk("press2_cyc", p2, 12);
`ifdef KEY_LONG_PRESS_EN
    chk("long2_cyc", l2, 62);
`else
    chk("long2_cyc", l2, -1);
`endif
    chk("rel2_cyc", r2, 92);

    // Keys 0 and 3 pressed and released together.
    apply_reset();
    p0 = -1; p3 = -1; r0x = -1; r3x = -1;
    for (int k = 0; k < 40; k++) begin
      key_in = (k < 20) ? 4'b0110 : 4'b1111;
      tick();
      if (key_press[0] && p0 < 0) p0 = k;
      if (key_press[3] && p3 < 0) p3 = k;
      if (key_release[0] && r0x < 0) r0x = k;
      if (key_release[3] && r3x < 0) r3x = k;
    end
    chk("sim_press0", p0, 12);
    chk("sim_press3", p3, 12);
    chk("sim_rel0", r0x, 32);
    chk("sim_rel3", r3x, 32);

    // Reset mid-debounce at cycle 7: progress must be discarded.
    apply_reset();
    for (int k = 0; k <= 7; k++) begin
      key_in[0] = 1'b0;
      tick();
    end
    sys_rst_n = 1'b0;
    model_reset();
    #1 compare();
    repeat (2) tick();
    sys_rst_n = 1'b1;
    p0 = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key_press[0] && p0 < 0) p0 = k;
    end
    chk("rst_press0_cyc", p0, 12);

    // Reset while a key is accepted as pressed clears outputs at once.
    sys_rst_n = 1'b0;
    model_reset();
    #1 chk("rst_async_level", 32'(key_level), 32'd0);
    compare();
    repeat (2) tick();
    sys_rst_n = 1'b1;

    // Random bouncing keys, with one reset in the middle.
    apply_reset();
    for (int i = 0; i < NK; i++) hold[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold[i] == 0) begin
          key_in[i] = ~key_in[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(11, 70))
                                                : int'($urandom_range(1, 12));
        end
        hold[i]--;
      end
      if (k == 1500) begin
        sys_rst_n = 1'b0;
        model_reset();
        #1 compare();
        tick();
        sys_rst_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
